// File: rtl/sata_test_pkg.sv
// Shared constants for the SATA test-pattern blocks: FSM state encodings
// and the pattern-mode selectors used by the generators.
package sata_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_WRITE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    localparam logic [1:0] PATTERN_INC   = 2'd0;
    localparam logic [1:0] PATTERN_LFSR  = 2'd1;
    localparam logic [1:0] PATTERN_CONST = 2'd2;
    localparam logic [1:0] PATTERN_WALK  = 2'd3;

endpackage

// File: rtl/ppfifo_pattern_source_pattern_gen.sv
// Registered test-word generator: load picks the start word and captures the
// mode, advance steps to the next word of that pattern.
module pattern_gen
    import sata_test_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] LFSR_POLY  = 32'h04C11DB7,
    parameter logic [31:0] LFSR_SEED  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] const_pattern,
    output logic [DATA_WIDTH-1:0] word
);

    localparam logic [DATA_WIDTH-1:0] POLY = LFSR_POLY[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] SEED = LFSR_SEED[DATA_WIDTH-1:0];

    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] start_word;
    logic [DATA_WIDTH-1:0] next_word;

    always_comb begin
        start_word = '0;
        case (mode)
            PATTERN_INC:   start_word = '0;
            PATTERN_LFSR:  start_word = SEED;
            PATTERN_CONST: start_word = const_pattern;
            PATTERN_WALK:  start_word = DATA_WIDTH'(1);
            default:       start_word = '0;
        endcase
    end

    // Constant mode simply holds the word captured at load time.
    always_comb begin
        next_word = word;
        case (mode_q)
            PATTERN_INC:   next_word = word + DATA_WIDTH'(1);
            PATTERN_LFSR:  next_word = {word[DATA_WIDTH-2:0], 1'b0} ^ (word[DATA_WIDTH-1] ? POLY : '0);
            PATTERN_CONST: next_word = word;
            PATTERN_WALK:  next_word = {word[DATA_WIDTH-2:0], word[DATA_WIDTH-1]};
            default:       next_word = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word   <= '0;
            mode_q <= PATTERN_INC;
        end else if (load) begin
            word   <= start_word;
            mode_q <= mode;
        end else if (advance) begin
            word   <= next_word;
        end
    end

endmodule

// File: rtl/ppfifo_pattern_source.sv
// Streams a selectable test pattern into a ping-pong FIFO: grabs a free
// buffer, fills it up to its size, releases it, and repeats until done.
module ppfifo_pattern_source
    import sata_test_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          COUNT_WIDTH = 24,
    parameter logic [31:0] LFSR_POLY   = 32'h04C11DB7,
    parameter logic [31:0] LFSR_SEED   = 32'hFFFFFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [DATA_WIDTH-1:0]  const_pattern,
    input  logic [COUNT_WIDTH-1:0] write_count,
    input  logic                   stall,
    input  logic [1:0]             ready,
    output logic [1:0]             activate,
    input  logic [COUNT_WIDTH-1:0] fifo_size,
    output logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   strobe,
    output logic                   finished,
    output logic [COUNT_WIDTH-1:0] words_sent
);

    state_t                 state;
    state_t                 next_state;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] burst_left;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [COUNT_WIDTH-1:0] burst_len;
    logic                   acquire_ok;
    logic                   load;
    logic                   last_word;

    assign remaining  = count_q - words_sent;
    assign burst_len  = (fifo_size < remaining) ? fifo_size : remaining;
    assign acquire_ok = (activate == 2'b00) && (ready != 2'b00) && (fifo_size != '0);
    assign last_word  = strobe && (burst_left == COUNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    next_state = (write_count == '0) ? ST_DONE : ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (acquire_ok) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (last_word) begin
                    next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (words_sent == count_q) begin
                    next_state = ST_DONE;
                end else if (!enable) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_ACQUIRE;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Strobe is gated by enable and rst directly so an abort or reset never
    // lets one more word slip out in the cycle it is requested.
    always_comb begin
        strobe   = 1'b0;
        finished = 1'b0;
        load     = 1'b0;
        case (state)
            ST_IDLE:  load     = enable;
            ST_WRITE: strobe   = enable && !stall && !rst;
            ST_DONE:  finished = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            activate   <= 2'b00;
            words_sent <= '0;
            count_q    <= '0;
            burst_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        count_q    <= write_count;
                        words_sent <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (!enable) begin
                        activate <= 2'b00;
                    end else if (acquire_ok) begin
                        activate   <= ready[0] ? 2'b01 : 2'b10;
                        burst_left <= burst_len;
                    end
                end
                ST_WRITE: begin
                    if (!enable) begin
                        activate <= 2'b00;
                    end else if (strobe) begin
                        words_sent <= words_sent + COUNT_WIDTH'(1);
                        burst_left <= burst_left - COUNT_WIDTH'(1);
                        if (last_word) begin
                            activate <= 2'b00;
                        end
                    end
                end
                default: activate <= 2'b00;
            endcase
        end
    end

    pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_POLY  (LFSR_POLY),
        .LFSR_SEED  (LFSR_SEED)
    ) u_pattern_gen (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .advance       (strobe),
        .mode          (mode),
        .const_pattern (const_pattern),
        .word          (fifo_data)
    );

endmodule

// File: tb/tb_ppfifo_pattern_source.sv
// Self-checking bench: table of runs plus hand-written abort/reset/size-0
// sequences, with a data/activate scoreboard fed by a reference pattern model.
module tb_ppfifo_pattern_source;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] const_pattern = 32'h0;
    logic [23:0] write_count = 24'd0;
    logic        stall = 1'b0;
    logic [1:0]  ready = 2'b11;
    logic [23:0] fifo_size = 24'd4;
    logic [1:0]  activate;
    logic [31:0] fifo_data;
    logic        strobe;
    logic        finished;
    logic [23:0] words_sent;

    logic [1:0]  activate8;
    logic [7:0]  fifo_data8;
    logic        strobe8;
    logic        finished8;
    logic [23:0] words_sent8;

    typedef struct packed {
        logic [1:0]  act;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] cpat;
        int          count;
        int          fsize;
        bit          stall_alt;
        bit          spacing;
        bit          chk8;
        int          exp_words;
        int          max_lat;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] exp8_q[$];
    exp_t       e_mon;
    logic [7:0] e8_mon;
    vec_t       vecs[7];

    int  checks = 0;
    int  failures = 0;
    int  strobe_cnt = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    bit  have_last = 1'b0;
    bit  spacing_en = 1'b0;
    bit  check8 = 1'b0;
    bit  stall_alt = 1'b0;
    logic [1:0] prev_act = 2'b00;

    ppfifo_pattern_source dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .mode          (mode),
        .const_pattern (const_pattern),
        .write_count   (write_count),
        .stall         (stall),
        .ready         (ready),
        .activate      (activate),
        .fifo_size     (fifo_size),
        .fifo_data     (fifo_data),
        .strobe        (strobe),
        .finished      (finished),
        .words_sent    (words_sent)
    );

    ppfifo_pattern_source #(.DATA_WIDTH(8)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .mode          (mode),
        .const_pattern (const_pattern[7:0]),
        .write_count   (write_count),
        .stall         (stall),
        .ready         (ready),
        .activate      (activate8),
        .fifo_size     (fifo_size),
        .fifo_data     (fifo_data8),
        .strobe        (strobe8),
        .finished      (finished8),
        .words_sent    (words_sent8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // FIFO reader model: a released buffer is busy until the other one is released.
    always @(posedge clk) begin
        #2;
        if (prev_act[0] && !activate[0]) ready = 2'b10;
        else if (prev_act[1] && !activate[1]) ready = 2'b01;
        prev_act = activate;
        stall = stall_alt ? ~stall : 1'b0;
    end

    function automatic logic [31:0] width_mask(input int width);
        return (width >= 32) ? 32'hFFFFFFFF : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] model_start(input logic [1:0] m, input logic [31:0] c, input int width);
        case (m)
            2'd0:    return 32'd0;
            2'd1:    return SEED & width_mask(width);
            2'd2:    return c & width_mask(width);
            default: return 32'd1;
        endcase
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] w, input logic [1:0] m, input int width);
        case (m)
            2'd0:    return (w + 32'd1) & width_mask(width);
            2'd1:    return ((w << 1) ^ (w[width-1] ? POLY : 32'd0)) & width_mask(width);
            2'd2:    return w;
            default: return ((w << 1) | (w >> (width - 1))) & width_mask(width);
        endcase
    endfunction

    always @(negedge clk) begin
        if (strobe) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_strobe data=%h act=%b (no word expected)", fifo_data, activate);
            end else begin
                e_mon = exp_q.pop_front();
                if (fifo_data !== e_mon.data || activate !== e_mon.act) begin
                    failures++;
                    $display("[TB] FAIL word_%0d data=%h act=%b expected data=%h act=%b",
                             strobe_cnt, fifo_data, activate, e_mon.data, e_mon.act);
                end
            end
            if (spacing_en) begin
                if (have_last) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin
                        failures++;
                        $display("[TB] FAIL strobe_spacing gap=%0d expected=2", cyc - last_cyc);
                    end
                end
                have_last = 1'b1;
                last_cyc = cyc;
            end
        end
        if (check8 && strobe8) begin
            checks++;
            if (exp8_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_strobe8 data=%h", fifo_data8);
            end else begin
                e8_mon = exp8_q.pop_front();
                if (fifo_data8 !== e8_mon || activate8 == 2'b00) begin
                    failures++;
                    $display("[TB] FAIL word8 data=%h act=%b expected data=%h act!=00", fifo_data8, activate8, e8_mon);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic pushRun(input logic [1:0] m, input logic [31:0] c, input int count, input int fsize);
        exp_t        e;
        logic [31:0] w;
        w = model_start(m, c, 32);
        for (int i = 0; i < count; i++) begin
            e.act  = (((i / fsize) % 2) == 0) ? 2'b01 : 2'b10;
            e.data = w;
            exp_q.push_back(e);
            w = model_next(w, m, 32);
        end
    endtask

    task automatic waitFinished(input string name, input int limit, input int start);
        int n;
        n = start;
        while (!finished && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, finished}, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] w8;
        enable = 1'b0;
        mode = v.mode;
        const_pattern = v.cpat;
        write_count = 24'(v.count);
        fifo_size = 24'(v.fsize);
        ready = 2'b11;
        stall_alt = v.stall_alt;
        spacing_en = v.spacing;
        have_last = 1'b0;
        check8 = v.chk8;
        if (v.count > 0) pushRun(v.mode, v.cpat, v.count, v.fsize);
        if (v.chk8) begin
            w8 = model_start(v.mode, v.cpat, 8);
            for (int i = 0; i < v.count; i++) begin
                exp8_q.push_back(w8[7:0]);
                w8 = model_next(w8, v.mode, 8);
            end
        end
        @(posedge clk) #1 enable = 1'b1;
        // Inputs scrambled once the run has started must not affect it.
        @(posedge clk) #1;
        mode = ~v.mode;
        const_pattern = ~v.cpat;
        write_count = 24'(v.count + 5);
        waitFinished("finished_in_time", v.max_lat, 1);
        checkOutput("all_words_sent", exp_q.size(), 32'd0);
        checkOutput("words_sent", {8'd0, words_sent}, v.exp_words);
        checkOutput("done_activate", {30'd0, activate}, 32'd0);
        checkOutput("done_strobe", {31'd0, strobe}, 32'd0);
        @(negedge clk);
        checkOutput("done_hold", {31'd0, finished}, 32'd1);
        if (v.chk8) begin
            checkOutput("all_words8", exp8_q.size(), 32'd0);
            checkOutput("words_sent8", {8'd0, words_sent8}, v.exp_words);
            checkOutput("finished8", {31'd0, finished8}, 32'd1);
        end
        stall_alt = 1'b0;
        @(posedge clk) #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("finished_clear", {31'd0, finished}, 32'd0);
        spacing_en = 1'b0;
        check8 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base;
        int n;
        vecs[0] = '{2'd0, 32'h0,        10, 4,  1'b0, 1'b0, 1'b0, 10, 100};
        vecs[1] = '{2'd1, 32'h0,        3,  4,  1'b0, 1'b0, 1'b0, 3,  50};
        vecs[2] = '{2'd3, 32'h0,        9,  4,  1'b0, 1'b0, 1'b1, 9,  100};
        vecs[3] = '{2'd0, 32'h0,        0,  4,  1'b0, 1'b0, 1'b0, 0,  2};
        vecs[4] = '{2'd0, 32'h0,        8,  16, 1'b1, 1'b1, 1'b0, 8,  100};
        vecs[5] = '{2'd2, 32'hA5C30F1E, 5,  2,  1'b0, 1'b0, 1'b0, 5,  100};
        vecs[6] = '{2'd3, 32'h0,        33, 16, 1'b0, 1'b0, 1'b0, 33, 200};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_activate", {30'd0, activate}, 32'd0);
        checkOutput("reset_strobe", {31'd0, strobe}, 32'd0);
        checkOutput("reset_finished", {31'd0, finished}, 32'd0);
        checkOutput("reset_words_sent", {8'd0, words_sent}, 32'd0);
        checkOutput("reset_fifo_data", fifo_data, 32'd0);
        @(posedge clk) #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            $display("[TB] run %0d mode=%0d count=%0d fifo_size=%0d", i, vecs[i].mode, vecs[i].count, vecs[i].fsize);
            applyStimulus(vecs[i]);
        end

        // Zero-size FIFO: buffer is not taken until a usable size appears.
        $display("[TB] fifo_size zero sequence");
        mode = 2'd0; write_count = 24'd3; fifo_size = 24'd0; ready = 2'b11;
        pushRun(2'd0, 32'h0, 3, 3);
        base = strobe_cnt;
        @(posedge clk) #1 enable = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("fsize0_activate", {30'd0, activate}, 32'd0);
        checkOutput("fsize0_no_strobe", strobe_cnt, base);
        fifo_size = 24'd3;
        waitFinished("fsize0_finished", 20, 0);
        checkOutput("fsize0_drained", exp_q.size(), 32'd0);
        @(posedge clk) #1 enable = 1'b0;
        repeat (2) @(posedge clk);

        // Abort after three words of a four-word burst, then restart.
        $display("[TB] abort sequence");
        mode = 2'd0; write_count = 24'd10; fifo_size = 24'd4; ready = 2'b11;
        pushRun(2'd0, 32'h0, 10, 4);
        base = strobe_cnt;
        @(posedge clk) #1 enable = 1'b1;
        n = 0;
        while (strobe_cnt < base + 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checkOutput("abort_three_words", strobe_cnt - base, 32'd3);
        #1 enable = 1'b0;
        @(negedge clk);
        checkOutput("abort_strobe_stop", {31'd0, strobe}, 32'd0);
        @(negedge clk);
        checkOutput("abort_activate", {30'd0, activate}, 32'd0);
        checkOutput("abort_finished", {31'd0, finished}, 32'd0);
        checkOutput("abort_words_sent", {8'd0, words_sent}, 32'd3);
        exp_q.delete();
        repeat (4) @(negedge clk);
        checkOutput("abort_no_more", strobe_cnt - base, 32'd3);
        write_count = 24'd4; ready = 2'b11;
        pushRun(2'd0, 32'h0, 4, 4);
        @(posedge clk) #1 enable = 1'b1;
        waitFinished("restart_finished", 40, 0);
        checkOutput("restart_drained", exp_q.size(), 32'd0);
        @(posedge clk) #1 enable = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the middle of a burst.
        $display("[TB] reset mid-burst sequence");
        write_count = 24'd10; fifo_size = 24'd4; ready = 2'b11;
        pushRun(2'd0, 32'h0, 10, 4);
        base = strobe_cnt;
        @(posedge clk) #1 enable = 1'b1;
        n = 0;
        while (strobe_cnt < base + 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk) #1;
        @(negedge clk);
        checkOutput("rst_mid_activate", {30'd0, activate}, 32'd0);
        checkOutput("rst_mid_words_sent", {8'd0, words_sent}, 32'd0);
        checkOutput("rst_mid_fifo_data", fifo_data, 32'd0);
        checkOutput("rst_mid_finished", {31'd0, finished}, 32'd0);
        enable = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_strobes", strobe_cnt - base, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
